// File: rtl/cla_seq_ctrl.sv
// Purpose     : multi-cycle carry-lookahead adder sequencer, CHUNK_WIDTH bits resolved per cycle.
// Latency     : result valid NUM_CHUNKS edges after the accept edge; one op per NUM_CHUNKS+2 cycles.
// Backpressure: result (sum_o/c_o/ovf_o) held stable in DONE until ready_i; no accept while BUSY/DONE.
//
// Ports
//   clk_i, rst_i       : clock (rising edge), asynchronous active-high reset
//   valid_i / ready_o  : request handshake; x_i, y_i, c_i sampled only on accept
//   valid_o / ready_i  : result handshake; sum_o = x+y+c mod 2^DATA_WIDTH,
//                        c_o = carry out of MSB, ovf_o = signed overflow
//
// DATA_WIDTH must be an integer multiple of CHUNK_WIDTH.
// All outputs come straight from registers; there is no input-to-output combinational path.

module cla_seq_ctrl #(
    parameter int DATA_WIDTH  = 64,
    parameter int CHUNK_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] x_i,
    input  logic [DATA_WIDTH-1:0] y_i,
    input  logic                  c_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] sum_o,
    output logic                  c_o,
    output logic                  ovf_o
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   x_q, x_d;
    logic [DATA_WIDTH-1:0]   y_q, y_d;
    logic [DATA_WIDTH-1:0]   sum_q, sum_d;
    logic                    carry_q, carry_d;
    logic                    cout_q, cout_d;
    logic                    ovf_q, ovf_d;
    logic                    ready_q, ready_d;
    logic                    valid_q, valid_d;

    // Single-chunk lookahead datapath. Operand registers shift right by one
    // chunk per BUSY cycle, so the active chunk always sits in the low bits
    // and no variable part-select is needed.
    logic [CHUNK_WIDTH-1:0]  g_w;
    logic [CHUNK_WIDTH-1:0]  p_w;
    logic [CHUNK_WIDTH:0]    c_w;
    logic [CHUNK_WIDTH-1:0]  chunk_sum_w;

    always_comb begin
        g_w    = x_q[CHUNK_WIDTH-1:0] & y_q[CHUNK_WIDTH-1:0];
        p_w    = x_q[CHUNK_WIDTH-1:0] ^ y_q[CHUNK_WIDTH-1:0];
        c_w    = '0;
        c_w[0] = carry_q;
        for (int j = 0; j < CHUNK_WIDTH; j++) begin
            c_w[j+1] = g_w[j] | (p_w[j] & c_w[j]);
        end
        chunk_sum_w = p_w ^ c_w[CHUNK_WIDTH-1:0];
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                // ready_q gates the accept so nothing is taken on the
                // first cycle after reset release.
                if (valid_i && ready_q) begin
                    x_d     = x_i;
                    y_d     = y_i;
                    carry_d = c_i;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end

            S_BUSY: begin
                x_d     = x_q >> CHUNK_WIDTH;
                y_d     = y_q >> CHUNK_WIDTH;
                // Resolved chunk enters from the MSB end; after NUM_CHUNKS
                // shifts chunk 0 has reached the LSB position.
                sum_d   = sum_q >> CHUNK_WIDTH;
                sum_d[DATA_WIDTH-1 -: CHUNK_WIDTH] = chunk_sum_w;
                carry_d = c_w[CHUNK_WIDTH];
                if (cnt_q == LAST_CNT) begin
                    cout_d  = c_w[CHUNK_WIDTH];
                    // carry into MSB xor carry out of MSB
                    ovf_d   = c_w[CHUNK_WIDTH] ^ c_w[CHUNK_WIDTH-1];
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake outputs are registered copies of where the FSM is going.
        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign sum_o   = sum_q;
    assign c_o     = cout_q;
    assign ovf_o   = ovf_q;

endmodule
